interrupt_controller: RTL and testbench
=======================================

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 SHALL have parameter INT_CTRL_ADDRESS, default 8'h00, base address of the 4-byte register window (offsets 0-3).
REQ-002 SHALL have port clk, input, 1, rising-edge clock.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port din, input, 8, bus write data.
REQ-005 SHALL have port address, input, 8, bus address.
REQ-006 SHALL have port w_en, input, 1, bus write strobe.
REQ-007 SHALL have port r_en, input, 1, bus read strobe.
REQ-008 SHALL have port dout, output reg, 8, registered read data.
REQ-009 SHALL have port irq_in, input, 8, single-cycle interrupt pulses from peripherals (bit 0 = timer top_flag, bit 1 = match0_flag, bit 2 = match1_flag, bits 3-7 = other sources).
REQ-010 SHALL have port int_req, output, 1, interrupt request to CPU.
REQ-011 SHALL have port int_vector, output, 3, index of the requesting source, valid while int_req = 1.
REQ-012 SHALL have port int_ack, input, 1, CPU acknowledge, sampled on clk.

Function
REQ-013 SHALL map offset 0 to PENDING (read; write 1 clears a bit), 1 to MASK (R/W, 1 = enabled), 2 to CONTROL (bit 0 GIE R/W; bit 1 EOI write-only, reads 0), 3 to STATUS (read-only: bit 7 = in service, bits 2:0 = in-service vector).
REQ-014 SHALL update dout on the clock edge after r_en at a mapped offset; SHALL load dout with 0 whenever the address is outside the window; SHALL otherwise hold dout.
REQ-015 SHALL set PENDING[i] on the edge following any cycle in which irq_in[i] = 1, regardless of MASK and GIE.
REQ-016 SHALL, when set and clear of the same PENDING bit coincide (irq_in with W1C write or with acknowledge), make set win.
REQ-017 SHALL implement FSM states IDLE, REQUEST, SERVICE.
REQ-018 SHALL, in IDLE with GIE = 1 and (PENDING & MASK) != 0, go to REQUEST on the next edge and latch int_vector = lowest set index of (PENDING & MASK) (bit 0 highest priority).
REQ-019 SHALL drive int_req = 1 exactly while in REQUEST; int_vector SHALL remain stable throughout REQUEST.
REQ-020 SHALL, in REQUEST with int_ack = 1, clear PENDING[int_vector], record it in STATUS, and go to SERVICE on the same edge.
REQ-021 SHALL, in REQUEST with GIE = 0 or MASK[int_vector] = 0 and int_ack = 0, return to IDLE with PENDING unchanged; int_ack SHALL win if both coincide.
REQ-022 SHALL, in SERVICE, ignore new pending sources until a CONTROL write with din[1] = 1 (EOI), then go to IDLE and clear STATUS bit 7.
REQ-023 SHALL ignore int_ack outside REQUEST and EOI outside SERVICE.
REQ-024 SHALL allow re-request of the same source once it has pended again after EOI; the minimum IDLE-to-REQUEST latency SHALL be 1 cycle.

Reset
REQ-025 SHALL, on rst, clear PENDING, MASK, CONTROL, STATUS, and dout; force FSM to IDLE; and drive int_req = 0 and int_vector = 0, including mid-REQUEST or mid-SERVICE.
REQ-026 SHALL ignore irq_in during a cycle in which rst = 1.

Configuration
REQ-027 SHALL, with INT_CTRL_AUTO_EOI_EN defined, go from REQUEST directly to IDLE on int_ack (no SERVICE state; STATUS bit 7 always 0; EOI writes ignored).
REQ-028 SHALL, without INT_CTRL_AUTO_EOI_EN, behave as REQ-020 to REQ-022.

Verification
REQ-029 SHALL cover the following case: MASK = 8'h07, GIE = 1, pulse irq_in[1] -> PENDING = 8'h02 after 1 edge, int_req = 1 and int_vector = 1 after 2 edges.
REQ-030 SHALL cover the following case: pulse irq_in = 8'h06 together -> vector 1; after int_ack and EOI, vector 2 is requested next.
REQ-031 SHALL cover the following case: irq_in[0] pulses while MASK = 0 -> no int_req; PENDING = 8'h01; writing MASK = 8'h01 -> int_req on the following edge.
REQ-032 SHALL cover the following case: W1C write of 8'h01 to PENDING in the same cycle as an irq_in[0] pulse -> PENDING[0] remains 1.
REQ-033 SHALL cover the following case: in SERVICE, a new irq_in[0] pulse -> int_req stays 0 until EOI, then int_req = 1 with vector 0; STATUS reads 8'h81 during SERVICE of vector 1.
REQ-034 SHALL cover the following case: rst asserted during REQUEST -> int_req = 0 and all registers read 0 on the next edge.

Source files
------------

// File: rtl/interrupt_controller.sv
// interrupt_controller
//   Eight-source prioritised interrupt controller with a 4-byte register window.
//   Offset 0 PENDING (R, write-1-to-clear), 1 MASK (R/W), 2 CONTROL (bit0 GIE R/W,
//   bit1 EOI write-only), 3 STATUS (R: bit7 in service, bits 2:0 in-service vector).
//   Source 0 has the highest priority.
//
//   Optional build macro: INT_CTRL_AUTO_EOI_EN -- acknowledge returns straight to
//   IDLE; no SERVICE state, STATUS bit 7 stays 0 and EOI writes are ignored.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   din, address     bus write data / bus address
//   w_en, r_en       bus write / read strobes
//   dout             registered read data (0 while address is outside the window)
//   irq_in           single-cycle interrupt pulses from peripherals
//   int_req          interrupt request to the CPU
//   int_vector       index of the requesting source, valid while int_req = 1
//   int_ack          CPU acknowledge
module interrupt_controller #(
    parameter logic [7:0] INT_CTRL_ADDRESS = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic [7:0] address,
    input  logic       w_en,
    input  logic       r_en,
    output logic [7:0] dout,
    input  logic [7:0] irq_in,
    output logic       int_req,
    output logic [2:0] int_vector,
    input  logic       int_ack
);

    typedef enum logic [1:0] {IDLE, REQUEST, SERVICE} state_t;

    state_t     state;
    logic [7:0] pending;
    logic [7:0] mask;
    logic       gie;
    logic       in_service;
    logic [2:0] service_vec;

    // Offset relative to the base; works for any base, aligned or not.
    logic [7:0] offset;
    logic       in_window;
    assign offset    = address - INT_CTRL_ADDRESS;
    assign in_window = (offset < 8'd4);

    logic wr_pending, wr_mask, wr_control;
    assign wr_pending = w_en && in_window && (offset[1:0] == 2'd0);
    assign wr_mask    = w_en && in_window && (offset[1:0] == 2'd1);
    assign wr_control = w_en && in_window && (offset[1:0] == 2'd2);

    logic [7:0] active;
    assign active = pending & mask;

    function automatic logic [2:0] lowest_set(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (v[i]) idx = 3'(i);
        return idx;
    endfunction

    logic ack_now;
    assign ack_now = (state == REQUEST) && int_ack;

    // Clears from W1C and acknowledge; new pulses are OR'd in afterwards so set wins.
    logic [7:0] clear_bits;
    logic [7:0] pending_next;
    always_comb begin
        clear_bits = 8'h00;
        if (wr_pending) clear_bits = clear_bits | din;
        if (ack_now)    clear_bits = clear_bits | (8'h01 << int_vector);
        pending_next = (pending & ~clear_bits) | irq_in;
    end

    logic [7:0] read_data;
    always_comb begin
        read_data = 8'h00;
        case (offset[1:0])
            2'd0: read_data = pending;
            2'd1: read_data = mask;
            2'd2: read_data = {7'b0, gie};
            2'd3: read_data = {in_service, 4'b0, service_vec};
            default: read_data = 8'h00;
        endcase
    end

    // Register file and bus read port
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 8'h00;
            mask    <= 8'h00;
            gie     <= 1'b0;
            dout    <= 8'h00;
        end else begin
            pending <= pending_next;
            if (wr_mask)    mask <= din;
            if (wr_control) gie  <= din[0];
            if (!in_window)
                dout <= 8'h00;
            else if (r_en)
                dout <= read_data;
        end
    end

    // Request / service FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            int_req     <= 1'b0;
            int_vector  <= 3'd0;
            in_service  <= 1'b0;
            service_vec <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (gie && (active != 8'h00)) begin
                        state      <= REQUEST;
                        int_req    <= 1'b1;
                        int_vector <= lowest_set(active);
                    end
                end
                REQUEST: begin
                    // Acknowledge takes precedence over a withdrawn request.
                    if (int_ack) begin
                        int_req     <= 1'b0;
                        service_vec <= int_vector;
`ifdef INT_CTRL_AUTO_EOI_EN
                        state       <= IDLE;
`else
                        state       <= SERVICE;
                        in_service  <= 1'b1;
`endif
                    end else if (!gie || !mask[int_vector]) begin
                        state   <= IDLE;
                        int_req <= 1'b0;
                    end
                end
                SERVICE: begin
`ifndef INT_CTRL_AUTO_EOI_EN
                    if (wr_control && din[1]) begin
                        state      <= IDLE;
                        in_service <= 1'b0;
                    end
`else
                    state <= IDLE;
`endif
                end
                default: begin
                    state   <= IDLE;
                    int_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
module tb_interrupt_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic [7:0] address;
    logic       w_en;
    logic       r_en;
    logic [7:0] dout;
    logic [7:0] irq_in;
    logic       int_req;
    logic [2:0] int_vector;
    logic       int_ack;

    int vectors = 0;
    int errors  = 0;

    interrupt_controller #(.INT_CTRL_ADDRESS(8'h00)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .address   (address),
        .w_en      (w_en),
        .r_en      (r_en),
        .dout      (dout),
        .irq_in    (irq_in),
        .int_req   (int_req),
        .int_vector(int_vector),
        .int_ack   (int_ack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        address = a; din = d; w_en = 1'b1;
        tick();
        w_en = 1'b0; din = 8'h00; address = 8'h00;
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
        address = a; r_en = 1'b1;
        tick();
        r_en = 1'b0; address = 8'h00;
        chk(tag, dout, exp);
    endtask

    task automatic pulse(input logic [7:0] v);
        irq_in = v;
        tick();
        irq_in = 8'h00;
    endtask

    task automatic ack();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; din = 8'h00; address = 8'h00; w_en = 1'b0; r_en = 1'b0;
        irq_in = 8'h00; int_ack = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        chk("rst_int_req", {7'b0, int_req}, 8'h00);
        chk("rst_vector", {5'b0, int_vector}, 8'h00);
        chk("rst_dout", dout, 8'h00);
        rd("rst_pending", 8'h00, 8'h00);
        rd("rst_mask", 8'h01, 8'h00);
        rd("rst_control", 8'h02, 8'h00);
        rd("rst_status", 8'h03, 8'h00);

        // Single source: pending after 1 edge, request after 2
        wr(8'h01, 8'h07);
        wr(8'h02, 8'h01);
        rd("mask_rb", 8'h01, 8'h07);
        pulse(8'h02);
        chk("req_after1", {7'b0, int_req}, 8'h00);
        tick();
        chk("req_after2", {7'b0, int_req}, 8'h01);
        chk("vec_after2", {5'b0, int_vector}, 8'h01);
        rd("pending_02", 8'h00, 8'h02);
        chk("req_held", {7'b0, int_req}, 8'h01);
        chk("vec_held", {5'b0, int_vector}, 8'h01);

        // Acknowledge -> SERVICE
        ack();
        chk("req_after_ack", {7'b0, int_req}, 8'h00);
        rd("status_81", 8'h03, 8'h81);
        rd("pending_cleared", 8'h00, 8'h00);

        // New pulse during SERVICE waits for EOI
        pulse(8'h01);
        tick(); tick();
        chk("svc_blocks", {7'b0, int_req}, 8'h00);
        wr(8'h02, 8'h03);
        chk("eoi_edge", {7'b0, int_req}, 8'h00);
        rd("control_eoi_reads0", 8'h02, 8'h01);
        chk("req_after_eoi", {7'b0, int_req}, 8'h01);
        chk("vec_after_eoi", {5'b0, int_vector}, 8'h00);
        ack();
        wr(8'h02, 8'h03);
        rd("status_idle", 8'h03, 8'h00);

        // Two sources together: 1 then 2
        pulse(8'h06);
        tick();
        chk("pair_req1", {7'b0, int_req}, 8'h01);
        chk("pair_vec1", {5'b0, int_vector}, 8'h01);
        ack();
        wr(8'h02, 8'h03);
        tick();
        chk("pair_req2", {7'b0, int_req}, 8'h01);
        chk("pair_vec2", {5'b0, int_vector}, 8'h02);
        ack();
        wr(8'h02, 8'h03);

        // Masked source pends without a request, then unmasking requests
        wr(8'h01, 8'h00);
        pulse(8'h01);
        tick(); tick();
        chk("masked_noreq", {7'b0, int_req}, 8'h00);
        rd("masked_pending", 8'h00, 8'h01);
        wr(8'h01, 8'h01);
        chk("unmask_edge", {7'b0, int_req}, 8'h00);
        tick();
        chk("unmask_req", {7'b0, int_req}, 8'h01);
        chk("unmask_vec", {5'b0, int_vector}, 8'h00);
        ack();
        wr(8'h02, 8'h03);

        // GIE withdrawn during REQUEST -> IDLE, pending kept
        wr(8'h01, 8'h07);
        pulse(8'h04);
        tick();
        chk("gie_req", {7'b0, int_req}, 8'h01);
        wr(8'h02, 8'h00);
        chk("gie_off_edge", {7'b0, int_req}, 8'h01);
        tick();
        chk("gie_withdrawn", {7'b0, int_req}, 8'h00);
        rd("gie_pending_kept", 8'h00, 8'h04);
        wr(8'h00, 8'h04);
        rd("w1c_clears", 8'h00, 8'h00);

        // W1C colliding with a new pulse: set wins
        address = 8'h00; din = 8'h01; w_en = 1'b1; irq_in = 8'h01;
        tick();
        w_en = 1'b0; din = 8'h00; irq_in = 8'h00;
        rd("set_wins", 8'h00, 8'h01);
        wr(8'h00, 8'h01);

        // Out-of-window address loads zero
        pulse(8'h08);
        rd("pending_08", 8'h00, 8'h08);
        address = 8'h10;
        tick();
        chk("outside_zero", dout, 8'h00);
        address = 8'h00;

        // Reset during REQUEST; irq_in ignored while rst = 1
        wr(8'h01, 8'h08);
        wr(8'h02, 8'h01);
        tick();
        chk("pre_rst_req", {7'b0, int_req}, 8'h01);
        chk("pre_rst_vec", {5'b0, int_vector}, 8'h03);
        rst = 1'b1; irq_in = 8'hff;
        tick();
        rst = 1'b0; irq_in = 8'h00;
        chk("rst_req_clear", {7'b0, int_req}, 8'h00);
        chk("rst_vec_clear", {5'b0, int_vector}, 8'h00);
        chk("rst_dout_clear", dout, 8'h00);
        rd("post_rst_pending", 8'h00, 8'h00);
        rd("post_rst_mask", 8'h01, 8'h00);
        rd("post_rst_control", 8'h02, 8'h00);
        rd("post_rst_status", 8'h03, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
